axi_log_drain: RTL and testbench

Readout stage downstream of the AXI BRAM logger. On command, it reads a given number of 96-bit log entries from the logger BRAM through a read-only BRAM port. Each entry is serialised into three 32-bit words and emitted on a valid/ready stream toward the host DMA/FIFO. It has one read outstanding at most, backpressure-safe output, and done/abort control.

---
 rtl/axi_log_drain.sv | 121 ++++++++++++
 tb/tb_axi_log_drain.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_log_drain.sv
// axi_log_drain: drains N 96-bit logger BRAM entries as three 32-bit stream words each
// Ports: Clk_CI/Rst_RI clock and sync active-high reset; Start_SI/NumEntries_DI/Abort_SI command;
// Busy_SO/Done_SO status; BramEn_SO/BramAddr_SO/BramRd_DI read-only BRAM port (1-cycle latency);
// OutValid_SO/OutReady_SI/OutData_DO/OutLast_SO valid/ready word stream.
module axi_log_drain #(
  parameter  int NUM_LOG_ENTRIES = 16384,
  parameter  int ENTRY_DATA_BITW = 96,
  parameter  int ADDR_WORD_BITO  = 4,
  parameter  int BRAM_ADDR_BITW  = 32,
  localparam int CNT_BITW        = $clog2(NUM_LOG_ENTRIES) + 1
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RI,
  input  logic                       Start_SI,
  input  logic [CNT_BITW-1:0]        NumEntries_DI,
  input  logic                       Abort_SI,
  output logic                       Busy_SO,
  output logic                       Done_SO,
  output logic                       BramEn_SO,
  output logic [BRAM_ADDR_BITW-1:0]  BramAddr_SO,
  input  logic [ENTRY_DATA_BITW-1:0] BramRd_DI,
  output logic                       OutValid_SO,
  input  logic                       OutReady_SI,
  output logic [31:0]                OutData_DO,
  output logic                       OutLast_SO
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND, S_DONE} state_e;
  state_e                    state_q;
  logic [CNT_BITW-1:0]       n_q, idx_q, idx_d;
  logic [1:0]                sel_q;
  logic [63:0]               hi_q;
  logic                      busy_q, done_q, en_q, valid_q, last_q, xfer, last_entry;
  logic [BRAM_ADDR_BITW-1:0] addr_q;
  logic [31:0]               data_q;
  always_comb begin
    xfer       = valid_q && OutReady_SI;
    idx_d      = idx_q + CNT_BITW'(1);
    last_entry = idx_d == n_q;
  end
  // Word 0 is loaded straight from the BRAM read data; only the upper 64 bits need buffering.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      en_q   <= 1'b0;
      if (Abort_SI && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (Start_SI) begin
            n_q   <= NumEntries_DI;
            idx_q <= '0;
            sel_q <= '0;
            if (NumEntries_DI == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_READ;
              busy_q  <= 1'b1;
              en_q    <= 1'b1;
              addr_q  <= '0;
            end
          end
          S_READ: state_q <= S_WAIT;
          S_WAIT: begin
            hi_q    <= BramRd_DI[95:32];
            data_q  <= BramRd_DI[31:0];
            last_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_SEND;
          end
          S_SEND: if (xfer) begin
            if (sel_q == 2'd2) begin
              sel_q   <= '0;
              idx_q   <= idx_d;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (last_entry) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_READ;
                en_q    <= 1'b1;
                addr_q  <= BRAM_ADDR_BITW'(idx_d) << ADDR_WORD_BITO;
              end
            end else begin
              sel_q  <= sel_q + 2'd1;
              data_q <= sel_q == 2'd0 ? hi_q[31:0] : hi_q[63:32];
              last_q <= sel_q == 2'd1 && last_entry;
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
  assign Busy_SO     = busy_q;
  assign Done_SO     = done_q;
  assign BramEn_SO   = en_q;
  assign BramAddr_SO = addr_q;
  assign OutValid_SO = valid_q;
  assign OutData_DO  = data_q;
  assign OutLast_SO  = last_q;
endmodule

// File: tb/tb_axi_log_drain.sv
// tb_axi_log_drain: randomized self-checking bench for axi_log_drain against a queue-based model
module tb_axi_log_drain;
  localparam int NUM = 64;
  localparam int CW  = $clog2(NUM) + 1;
  logic          Clk_CI = 1'b0, Rst_RI = 1'b1, Start_SI = 1'b0, Abort_SI = 1'b0, OutReady_SI = 1'b0;
  logic [CW-1:0] NumEntries_DI = '0;
  logic          Busy_SO, Done_SO, BramEn_SO, OutValid_SO, OutLast_SO;
  logic [31:0]   BramAddr_SO, OutData_DO;
  logic [95:0]   BramRd_DI;
  axi_log_drain #(.NUM_LOG_ENTRIES(NUM)) dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI), .Start_SI(Start_SI), .NumEntries_DI(NumEntries_DI),
    .Abort_SI(Abort_SI), .Busy_SO(Busy_SO), .Done_SO(Done_SO), .BramEn_SO(BramEn_SO),
    .BramAddr_SO(BramAddr_SO), .BramRd_DI(BramRd_DI), .OutValid_SO(OutValid_SO),
    .OutReady_SI(OutReady_SI), .OutData_DO(OutData_DO), .OutLast_SO(OutLast_SO)
  );
  always #5 Clk_CI = ~Clk_CI;
  logic [95:0] mem [NUM];
  logic [32:0] wq[$];
  logic [31:0] aq[$];
  int          vectors = 0, errs = 0, xfers = 0, dones = 0, reads = 0, valids = 0;
  logic [31:0] last_addr = '0;
  logic        hold = 1'b0, rmode = 1'b0;
  logic [32:0] prev = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  always @(posedge Clk_CI)
    BramRd_DI <= BramEn_SO ? mem[(BramAddr_SO >> 4) % NUM] : {$urandom, $urandom, $urandom};
  always @(negedge Clk_CI) begin
    if (Rst_RI) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", 64'(OutValid_SO), 1);
        chk("hold_data", 64'({OutLast_SO, OutData_DO}), 64'(prev));
      end
      if (OutValid_SO) valids++;
      if (OutValid_SO && OutReady_SI) begin
        xfers++;
        chk("word_expected", 64'(wq.size() != 0), 1);
        if (wq.size() != 0) chk("word", 64'({OutLast_SO, OutData_DO}), 64'(wq.pop_front()));
      end
      if (BramEn_SO) begin
        reads++;
        last_addr = BramAddr_SO;
        chk("read_expected", 64'(aq.size() != 0), 1);
        if (aq.size() != 0) chk("addr", 64'(BramAddr_SO), 64'(aq.pop_front()));
      end
      if (Done_SO) begin
        dones++;
        chk("done_words_left", 64'(wq.size()), 0);
        chk("done_reads_left", 64'(aq.size()), 0);
      end
      hold = OutValid_SO && !OutReady_SI && !Abort_SI;
      prev = {OutLast_SO, OutData_DO};
    end
  end
  task automatic tick();
    @(posedge Clk_CI);
    #1;
    if (rmode) OutReady_SI = 1'($urandom_range(0, 1));
  endtask
  task automatic start(input int n);
    for (int i = 0; i < n; i++) begin
      logic [95:0] e;
      e = mem[i % NUM];
      wq.push_back({1'b0, e[31:0]});
      wq.push_back({1'b0, e[63:32]});
      wq.push_back({i == n - 1, e[95:64]});
      aq.push_back(32'(i) << 4);
    end
    Start_SI      = 1'b1;
    NumEntries_DI = CW'(n);
    tick();
    Start_SI = 1'b0;
  endtask
  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!Done_SO && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("done_seen", 64'(Done_SO), 1);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(Busy_SO), 0);
    chk({tag, "_done"}, 64'(Done_SO), 0);
    chk({tag, "_en"}, 64'(BramEn_SO), 0);
    chk({tag, "_addr"}, 64'(BramAddr_SO), 0);
    chk({tag, "_valid"}, 64'(OutValid_SO), 0);
    chk({tag, "_data"}, 64'(OutData_DO), 0);
    chk({tag, "_last"}, 64'(OutLast_SO), 0);
  endtask
  initial begin
    int cyc, x0, d0, r0, v0;
    for (int i = 0; i < NUM; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[0] = {32'h0000_A508, 32'hDEAD_BEEF, 32'h0000_1234};
    repeat (3) tick();
    check_zero("reset");
    Rst_RI      = 1'b0;
    OutReady_SI = 1'b1;
    tick();
    x0 = xfers; d0 = dones;
    start(2);
    chk("lat_read_valid", 64'(OutValid_SO), 0);
    chk("lat_read_busy", 64'(Busy_SO), 1);
    wait_done(40, cyc);
    chk("n2_cycles", 64'(cyc + 1), 11);
    chk("n2_words", 64'(xfers - x0), 6);
    chk("n2_busy_in_done", 64'(Busy_SO), 0);
    tick();
    chk("n2_done_pulse", 64'(Done_SO), 0);
    chk("n2_dones", 64'(dones - d0), 1);
    r0 = reads; v0 = valids; d0 = dones;
    start(0);
    chk("n0_done", 64'(Done_SO), 1);
    chk("n0_busy", 64'(Busy_SO), 0);
    tick();
    chk("n0_done_pulse", 64'(Done_SO), 0);
    chk("n0_busy2", 64'(Busy_SO), 0);
    chk("n0_reads", 64'(reads - r0), 0);
    chk("n0_valids", 64'(valids - v0), 0);
    chk("n0_dones", 64'(dones - d0), 1);
    x0 = xfers;
    start(1);
    tick();
    chk("lat_wait_valid", 64'(OutValid_SO), 0);
    tick();
    chk("lat_send_valid", 64'(OutValid_SO), 1);
    chk("first_word", 64'(OutData_DO), 64'h1234);
    tick();
    OutReady_SI = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(OutValid_SO), 1);
      chk("stall_data", 64'(OutData_DO), 64'hDEAD_BEEF);
    end
    OutReady_SI = 1'b1;
    wait_done(40, cyc);
    chk("n1_words", 64'(xfers - x0), 3);
    tick();
    x0 = xfers; d0 = dones;
    start(4);
    cyc = 0;
    while (xfers - x0 < 4 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("abort_reach", 64'(xfers - x0 >= 4), 1);
    Abort_SI = 1'b1;
    tick();
    Abort_SI = 1'b0;
    chk("abort_valid", 64'(OutValid_SO), 0);
    chk("abort_busy", 64'(Busy_SO), 0);
    wq.delete();
    aq.delete();
    repeat (3) tick();
    chk("abort_no_done", 64'(dones - d0), 0);
    x0 = xfers;
    start(1);
    wait_done(40, cyc);
    chk("post_abort_words", 64'(xfers - x0), 3);
    chk("post_abort_addr", 64'(last_addr), 0);
    tick();
    x0 = xfers;
    start(3);
    repeat (4) tick();
    Start_SI      = 1'b1;
    NumEntries_DI = CW'(7);
    tick();
    Start_SI = 1'b0;
    wait_done(100, cyc);
    chk("restart_ignored_words", 64'(xfers - x0), 9);
    tick();
    d0 = dones;
    start(2);
    tick();
    Rst_RI = 1'b1;
    tick();
    check_zero("mid_reset");
    Rst_RI = 1'b0;
    wq.delete();
    aq.delete();
    tick();
    chk("mid_reset_no_done", 64'(dones - d0), 0);
    for (int i = 0; i < NUM; i++) mem[i] = {$urandom, $urandom, $urandom};
    rmode = 1'b1;
    x0 = xfers;
    start(NUM);
    wait_done(20000, cyc);
    chk("full_words", 64'(xfers - x0), 3 * NUM);
    chk("full_last_addr", 64'(last_addr), 64'((NUM - 1) << 4));
    tick();
    for (int r = 0; r < 6; r++) begin
      int n;
      n  = $urandom_range(1, NUM / 4);
      x0 = xfers;
      start(n);
      wait_done(3000, cyc);
      chk("rand_words", 64'(xfers - x0), 64'(3 * n));
      tick();
    end
    rmode = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
